// File: rtl/cpu_pkg.sv
// Shared definitions for the core pipeline interlock.
// Register index width, register count, the mul/div latency and the
// state type of the mul/div sequencer.
package cpu_pkg;

    localparam int unsigned RW     = 5;
    localparam int unsigned NREG   = 32;
    localparam int unsigned MD_LAT = 4;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_WB
    } md_state_e;

endpackage

// File: rtl/pipeline_interlock_if.sv
// Bundle between the core pipeline and the interlock controller.
// master : pipeline side, drives ID/EX decode info and receives stall/flush/mul-div controls.
// slave  : interlock side, the mirror image.
interface pipeline_interlock_if;
    import cpu_pkg::*;

    // ID stage
    logic          id_valid;
    logic [RW-1:0] id_rsa;
    logic          id_rsa_used;
    logic [RW-1:0] id_rsb;
    logic          id_rsb_used;
    logic [RW-1:0] id_rd;
    logic          id_is_muldiv;
    // EX stage
    logic          ex_legal;
    logic          ex_is_load;
    logic [RW-1:0] ex_rd;
    logic          ex_br_taken;
    // Controls back to the pipeline
    logic          stall_if;
    logic          stall_id;
    logic          bubble_ex;
    logic          flush_if;
    logic          flush_id;
    logic          md_issue;
    logic          md_busy;
    logic          md_wb_valid;
    logic [RW-1:0] md_wb_rd;

    modport master (
        output id_valid, id_rsa, id_rsa_used, id_rsb, id_rsb_used, id_rd, id_is_muldiv,
        output ex_legal, ex_is_load, ex_rd, ex_br_taken,
        input  stall_if, stall_id, bubble_ex, flush_if, flush_id,
        input  md_issue, md_busy, md_wb_valid, md_wb_rd
    );

    modport slave (
        input  id_valid, id_rsa, id_rsa_used, id_rsb, id_rsb_used, id_rd, id_is_muldiv,
        input  ex_legal, ex_is_load, ex_rd, ex_br_taken,
        output stall_if, stall_id, bubble_ex, flush_if, flush_id,
        output md_issue, md_busy, md_wb_valid, md_wb_rd
    );

endinterface

// File: rtl/md_sequencer.sv
// Sequencer for the single shared mul/div unit.
// Tracks IDLE -> BUSY -> WB, counts down the latency, holds the writeback
// destination and keeps the pending-result scoreboard (one bit per register).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   md_issue_i      mul/div accepted from ID this cycle
//   id_rd_i         destination of the issuing mul/div
//   state_o         current sequencer state
//   pending_o       per-register "result still in flight" flags, bit 0 always 0
//   md_busy_o       unit occupied (BUSY or WB)
//   md_wb_valid_o   one-cycle writeback strobe
//   md_wb_rd_o      writeback destination
module md_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned RW     = cpu_pkg::RW,
    parameter int unsigned NREG   = cpu_pkg::NREG,
    parameter int unsigned MD_LAT = cpu_pkg::MD_LAT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            md_issue_i,
    input  logic [RW-1:0]   id_rd_i,
    output md_state_e       state_o,
    output logic [NREG-1:0] pending_o,
    output logic            md_busy_o,
    output logic            md_wb_valid_o,
    output logic [RW-1:0]   md_wb_rd_o
);

    // Counter only ever holds MD_LAT-2 down to 0.
    localparam int unsigned CntW = (MD_LAT > 2) ? $clog2(MD_LAT - 1) : 1;

    md_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [RW-1:0]   wb_rd_q, wb_rd_d;
    logic [NREG-1:0] pending_q, pending_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            wb_rd_q   <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_rd_q   <= wb_rd_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wb_rd_d   = wb_rd_q;
        pending_d = pending_q;
        unique case (state_q)
            MD_IDLE: begin
                if (md_issue_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = CntW'(MD_LAT - 2);
                    wb_rd_d = id_rd_i;
                    pending_d[id_rd_i] = 1'b1;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_WB;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            MD_WB: begin
                // Issue is only possible from IDLE, so this clear never races a set.
                pending_d[wb_rd_q] = 1'b0;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        // r0 is hardwired zero and never has a result in flight.
        pending_d[0] = 1'b0;
    end

    assign state_o       = state_q;
    assign pending_o     = pending_q;
    assign md_busy_o     = (state_q != MD_IDLE);
    assign md_wb_valid_o = (state_q == MD_WB);
    assign md_wb_rd_o    = wb_rd_q;

endmodule

// File: rtl/pipeline_interlock.sv
// Hazard/interlock controller for the 5-stage core.
// Handles what forwarding cannot: load-use, reads/writes of registers whose
// mul/div result is still in flight, and the mul/div unit being occupied.
// A taken branch in EX flushes IF/ID and takes priority over every stall.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        pipeline_interlock_if.slave: ID/EX info in; stall, flush,
//              bubble and mul/div issue/writeback controls out
module pipeline_interlock
    import cpu_pkg::*;
#(
    parameter int unsigned RW     = cpu_pkg::RW,
    parameter int unsigned NREG   = cpu_pkg::NREG,
    parameter int unsigned MD_LAT = cpu_pkg::MD_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_interlock_if.slave   bus
);

    md_state_e       md_state;
    logic [NREG-1:0] pending;
    logic            md_busy;
    logic            md_wb_valid;
    logic [RW-1:0]   md_wb_rd;

    logic [RW-1:0]   rsa, rsb, id_rd, ex_rd;
    logic            src_a_ok, src_b_ok;
    logic            lu, raw, waw, strc, haz;
    logic            stall, flush, bubble, issue;

    assign rsa   = bus.id_rsa;
    assign rsb   = bus.id_rsb;
    assign id_rd = bus.id_rd;
    assign ex_rd = bus.ex_rd;

    // A source only counts if it is actually read and is not r0.
    assign src_a_ok = bus.id_rsa_used && (rsa != '0);
    assign src_b_ok = bus.id_rsb_used && (rsb != '0);

    assign lu   = bus.ex_legal && bus.ex_is_load && (ex_rd != '0) &&
                  ((src_a_ok && (rsa == ex_rd)) || (src_b_ok && (rsb == ex_rd)));
    assign raw  = (src_a_ok && pending[rsa]) || (src_b_ok && pending[rsb]);
    // A mul/div writing the same register is covered by strc instead.
    assign waw  = !bus.id_is_muldiv && (id_rd != '0) && pending[id_rd];
    assign strc = bus.id_is_muldiv && (md_state != MD_IDLE);
    assign haz  = bus.id_valid && (lu || raw || waw || strc);

    always_comb begin
        stall  = 1'b0;
        flush  = 1'b0;
        bubble = 1'b0;
        issue  = 1'b0;
        // Everything is forced quiet while reset is held.
        if (!rst) begin
            if (bus.ex_br_taken) begin
                flush  = 1'b1;
                bubble = 1'b1;
            end else if (haz) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
            issue = bus.id_valid && bus.id_is_muldiv && (md_state == MD_IDLE) &&
                    !haz && !bus.ex_br_taken;
        end
    end

    md_sequencer #(
        .RW     (RW),
        .NREG   (NREG),
        .MD_LAT (MD_LAT)
    ) u_seq (
        .clk           (clk),
        .rst           (rst),
        .md_issue_i    (issue),
        .id_rd_i       (id_rd),
        .state_o       (md_state),
        .pending_o     (pending),
        .md_busy_o     (md_busy),
        .md_wb_valid_o (md_wb_valid),
        .md_wb_rd_o    (md_wb_rd)
    );

    assign bus.stall_if    = stall;
    assign bus.stall_id    = stall;
    assign bus.bubble_ex   = bubble;
    assign bus.flush_if    = flush;
    assign bus.flush_id    = flush;
    assign bus.md_issue    = issue;
    assign bus.md_busy     = md_busy;
    assign bus.md_wb_valid = md_wb_valid;
    assign bus.md_wb_rd    = md_wb_rd;

endmodule

// File: tb/tb_pipeline_interlock.sv
// Bench for pipeline_interlock: a timeline model of the mul/div unit (issue
// cycle + latency) predicts every output each cycle, and directed scenarios
// pin key cycles with literal values.
module tb_pipeline_interlock;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_interlock_if bus ();

    pipeline_interlock #(
        .RW     (RW),
        .NREG   (NREG),
        .MD_LAT (MD_LAT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    int cyc      = 0;   // index of the current cycle
    bit inflight = 0;   // a mul/div issued and not yet retired
    int ti       = 0;   // cycle in which it issued
    int frd      = 0;   // its destination
    int last_rd  = 0;   // destination register value shown on md_wb_rd
    bit exp_issue_s = 0;
    int issue_rd_s  = 0;

    always @(negedge clk) begin : compare
        bit busy, a_ok, b_ok, lu, raw, waw, strc, haz;
        bit e_stall, e_flush, e_bubble, e_issue, e_busy, e_wb;
        int e_wbrd, ra, rb, rd, xr;
        ra = int'(bus.id_rsa);
        rb = int'(bus.id_rsb);
        rd = int'(bus.id_rd);
        xr = int'(bus.ex_rd);
        busy = inflight && (cyc >= ti + 1) && (cyc <= ti + int'(MD_LAT));
        a_ok = bus.id_rsa_used && ra != 0;
        b_ok = bus.id_rsb_used && rb != 0;
        lu   = bus.ex_legal && bus.ex_is_load && xr != 0 &&
               ((a_ok && ra == xr) || (b_ok && rb == xr));
        // A register is pending while its mul/div is in the unit and it is not r0.
        raw  = busy && frd != 0 && ((a_ok && ra == frd) || (b_ok && rb == frd));
        waw  = !bus.id_is_muldiv && busy && rd != 0 && rd == frd;
        strc = bus.id_is_muldiv && busy;
        haz  = bus.id_valid && (lu || raw || waw || strc);
        e_flush  = bus.ex_br_taken;
        e_stall  = !bus.ex_br_taken && haz;
        e_bubble = bus.ex_br_taken || haz;
        e_issue  = bus.id_valid && bus.id_is_muldiv && !busy && !haz && !bus.ex_br_taken;
        e_busy   = busy;
        e_wb     = busy && (cyc == ti + int'(MD_LAT));
        e_wbrd   = last_rd;
        if (rst) begin
            e_flush = 0; e_stall = 0; e_bubble = 0; e_issue = 0;
            e_busy = 0; e_wb = 0; e_wbrd = 0;
        end
        chk("cmp_stall_if",    32'(bus.stall_if),    32'(e_stall));
        chk("cmp_stall_id",    32'(bus.stall_id),    32'(e_stall));
        chk("cmp_bubble_ex",   32'(bus.bubble_ex),   32'(e_bubble));
        chk("cmp_flush_if",    32'(bus.flush_if),    32'(e_flush));
        chk("cmp_flush_id",    32'(bus.flush_id),    32'(e_flush));
        chk("cmp_md_issue",    32'(bus.md_issue),    32'(e_issue));
        chk("cmp_md_busy",     32'(bus.md_busy),     32'(e_busy));
        chk("cmp_md_wb_valid", 32'(bus.md_wb_valid), 32'(e_wb));
        chk("cmp_md_wb_rd",    32'(bus.md_wb_rd),    32'(e_wbrd));
        exp_issue_s = e_issue;
        issue_rd_s  = rd;
    end

    always @(posedge clk) begin : model_adv
        if (rst) begin
            inflight    = 0;
            last_rd     = 0;
            exp_issue_s = 0;
        end else if (exp_issue_s) begin
            inflight = 1;
            ti       = cyc;
            frd      = issue_rd_s;
            last_rd  = issue_rd_s;
        end
        cyc++;
        if (inflight && cyc > ti + int'(MD_LAT)) inflight = 0;
    end

    // ---------------- stimulus helpers ----------------
    task automatic id_set(input bit v, input int ra, input bit ua, input int rb, input bit ub,
                          input int rd, input bit md);
        bus.id_valid     = v;
        bus.id_rsa       = ra[RW-1:0];
        bus.id_rsa_used  = ua;
        bus.id_rsb       = rb[RW-1:0];
        bus.id_rsb_used  = ub;
        bus.id_rd        = rd[RW-1:0];
        bus.id_is_muldiv = md;
    endtask

    task automatic ex_set(input bit legal, input bit load, input int rd, input bit br);
        bus.ex_legal    = legal;
        bus.ex_is_load  = load;
        bus.ex_rd       = rd[RW-1:0];
        bus.ex_br_taken = br;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        id_set(0, 0, 0, 0, 0, 0, 0);
        ex_set(0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        mid();
        chk("rst_busy",  32'(bus.md_busy),  32'd0);
        chk("rst_wb_rd", 32'(bus.md_wb_rd), 32'd0);
        nxt();
        rst = 1'b0;
        nxt();

        // 1: load-use
        ex_set(1, 1, 5, 0); id_set(1, 5, 1, 0, 0, 6, 0);
        mid();
        chk("t1_stall_if",  32'(bus.stall_if),  32'd1);
        chk("t1_stall_id",  32'(bus.stall_id),  32'd1);
        chk("t1_bubble_ex", 32'(bus.bubble_ex), 32'd1);
        nxt();
        ex_set(1, 1, 0, 0);
        mid();
        chk("t1_r0_stall_if",  32'(bus.stall_if),  32'd0);
        chk("t1_r0_stall_id",  32'(bus.stall_id),  32'd0);
        chk("t1_r0_bubble_ex", 32'(bus.bubble_ex), 32'd0);
        nxt();
        ex_set(1, 1, 5, 0); id_set(1, 2, 1, 5, 1, 6, 0);
        mid();
        chk("t1_rsb_stall", 32'(bus.stall_id), 32'd1);
        nxt();
        id_set(1, 5, 0, 0, 0, 6, 0);
        mid();
        chk("t1_unused_stall", 32'(bus.stall_id), 32'd0);
        nxt();
        ex_set(0, 0, 0, 0); id_set(0, 0, 0, 0, 0, 0, 0);
        nxt();

        // 2: MUL r7 then a reader of r7
        id_set(1, 1, 1, 2, 1, 7, 1);
        mid();
        chk("t2_issue", 32'(bus.md_issue), 32'd1);
        nxt();
        id_set(1, 7, 1, 0, 0, 8, 0);
        for (int k = 1; k <= 5; k++) begin
            mid();
            if (k <= 4) begin
                chk("t2_stall", 32'(bus.stall_id), 32'd1);
                chk("t2_busy",  32'(bus.md_busy),  32'd1);
                chk("t2_wb",    32'(bus.md_wb_valid), (k == 4) ? 32'd1 : 32'd0);
                if (k == 4) chk("t2_wb_rd", 32'(bus.md_wb_rd), 32'd7);
            end else begin
                chk("t2_advance", 32'(bus.stall_id), 32'd0);
                chk("t2_idle",    32'(bus.md_busy),  32'd0);
            end
            nxt();
        end
        id_set(0, 0, 0, 0, 0, 0, 0);
        nxt();

        // 3: back-to-back MUL r3, MUL r4
        id_set(1, 0, 0, 0, 0, 3, 1);
        mid();
        chk("t3_issue_a", 32'(bus.md_issue), 32'd1);
        nxt();
        id_set(1, 0, 0, 0, 0, 4, 1);
        for (int k = 1; k <= 5; k++) begin
            mid();
            if (k < 5) begin
                chk("t3_held",  32'(bus.md_issue), 32'd0);
                chk("t3_stall", 32'(bus.stall_id), 32'd1);
                chk("t3_wb_a",  32'(bus.md_wb_valid), (k == 4) ? 32'd1 : 32'd0);
                if (k == 4) chk("t3_wb_rd_a", 32'(bus.md_wb_rd), 32'd3);
            end else begin
                chk("t3_issue_b", 32'(bus.md_issue), 32'd1);
                chk("t3_go",      32'(bus.stall_id), 32'd0);
            end
            nxt();
        end
        id_set(0, 0, 0, 0, 0, 0, 0);
        for (int k = 6; k <= 10; k++) begin
            mid();
            chk("t3_wb_b", 32'(bus.md_wb_valid), (k == 9) ? 32'd1 : 32'd0);
            if (k == 9) chk("t3_wb_rd_b", 32'(bus.md_wb_rd), 32'd4);
            nxt();
        end

        // 4: taken branch beats load-use and mul/div issue
        ex_set(1, 1, 5, 1); id_set(1, 5, 1, 0, 0, 9, 1);
        mid();
        chk("t4_flush_if",  32'(bus.flush_if),  32'd1);
        chk("t4_flush_id",  32'(bus.flush_id),  32'd1);
        chk("t4_bubble_ex", 32'(bus.bubble_ex), 32'd1);
        chk("t4_stall_if",  32'(bus.stall_if),  32'd0);
        chk("t4_stall_id",  32'(bus.stall_id),  32'd0);
        chk("t4_issue",     32'(bus.md_issue),  32'd0);
        nxt();
        ex_set(1, 1, 5, 0);
        mid();
        chk("t4_lu_stall", 32'(bus.stall_if), 32'd1);
        chk("t4_no_flush", 32'(bus.flush_if), 32'd0);
        nxt();
        ex_set(0, 0, 0, 0); id_set(0, 0, 0, 0, 0, 0, 0);
        mid();
        chk("t4_not_busy", 32'(bus.md_busy), 32'd0);
        nxt();

        // 5: reset during BUSY
        id_set(1, 0, 0, 0, 0, 7, 1);
        mid();
        chk("t5_issue", 32'(bus.md_issue), 32'd1);
        nxt();
        id_set(0, 0, 0, 0, 0, 0, 0);
        mid();
        chk("t5_busy", 32'(bus.md_busy), 32'd1);
        nxt();
        rst = 1'b1;
        id_set(1, 7, 1, 0, 0, 8, 0);
        mid();
        chk("t5_rst_busy",    32'(bus.md_busy),     32'd0);
        chk("t5_rst_stall",   32'(bus.stall_id),    32'd0);
        chk("t5_rst_wb",      32'(bus.md_wb_valid), 32'd0);
        chk("t5_rst_pending", u_dut.u_seq.pending_q, 32'd0);
        nxt();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mid();
            chk("t5_reader_go", 32'(bus.stall_id),    32'd0);
            chk("t5_no_wb",     32'(bus.md_wb_valid), 32'd0);
            nxt();
        end
        id_set(0, 0, 0, 0, 0, 0, 0);
        nxt();

        // 6: MUL r0, reader of r0
        id_set(1, 0, 0, 0, 0, 0, 1);
        mid();
        chk("t6_issue", 32'(bus.md_issue), 32'd1);
        nxt();
        id_set(1, 0, 1, 0, 1, 8, 0);
        for (int k = 1; k <= 5; k++) begin
            mid();
            chk("t6_no_stall", 32'(bus.stall_id), 32'd0);
            chk("t6_pend0",    32'(u_dut.u_seq.pending_q[0]), 32'd0);
            chk("t6_wb",       32'(bus.md_wb_valid), (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) chk("t6_wb_rd", 32'(bus.md_wb_rd), 32'd0);
            nxt();
        end

        // 7: write-after-write and rsb read against an in-flight MUL r12
        id_set(1, 0, 0, 0, 0, 12, 1);
        mid();
        chk("t7_issue", 32'(bus.md_issue), 32'd1);
        nxt();
        id_set(1, 0, 0, 0, 0, 12, 0);
        mid();
        chk("t7_waw", 32'(bus.stall_id), 32'd1);
        nxt();
        id_set(1, 3, 1, 12, 1, 9, 0);
        mid();
        chk("t7_raw_b", 32'(bus.stall_id), 32'd1);
        nxt();
        id_set(1, 3, 1, 4, 1, 9, 0);
        mid();
        chk("t7_clear", 32'(bus.stall_id), 32'd0);
        nxt();
        id_set(0, 0, 0, 0, 0, 0, 0);
        repeat (4) nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
